// File: rtl/player_shot_pkg.sv
// Shared types for the player shot pool: pixel coordinates and 6-bit-fraction fixed point.
package player_shot_pkg;
    localparam int FP_SHIFT = 6;

    typedef logic signed [10:0] coord_t;
    typedef logic signed [17:0] fixed_t;
endpackage

// File: rtl/player_shot_pool_if.sv
// Fire/hit handshake and per-slot position bus between the shot pool and game logic.
interface player_shot_pool_if
    import player_shot_pkg::*;
    #(parameter int NUM_SHOTS = 4) ();

    logic                               fireReq;
    coord_t                             playerXPosition;
    logic   [NUM_SHOTS-1:0]             hitMask;
    coord_t [NUM_SHOTS-1:0]             topLeftX;
    coord_t [NUM_SHOTS-1:0]             topLeftY;
    logic   [NUM_SHOTS-1:0]             alive;
    logic                               fireAccepted;
    logic   [$clog2(NUM_SHOTS+1)-1:0]   shotsInFlight;

    modport master (
        output fireReq, playerXPosition, hitMask,
        input  topLeftX, topLeftY, alive, fireAccepted, shotsInFlight
    );

    modport slave (
        input  fireReq, playerXPosition, hitMask,
        output topLeftX, topLeftY, alive, fireAccepted, shotsInFlight
    );
endinterface

// File: rtl/player_shot_slot.sv
// One shot slot: fixed-point position, alive flag, per-frame upward motion and off-screen kill.
module player_shot_slot
    import player_shot_pkg::*;
    #(
        parameter int SHOT_Y_START = 400,
        parameter int Y_SPEED      = -320
    ) (
        input  logic   clk,
        input  logic   resetN,
        input  logic   clear,
        input  logic   hit,
        input  logic   spawn,
        input  logic   move,
        input  fixed_t spawnX,
        output logic   alive,
        output coord_t pixX,
        output coord_t pixY
    );

    localparam fixed_t Y_RESET = fixed_t'(SHOT_Y_START) <<< FP_SHIFT;

    fixed_t x;
    fixed_t y;
    fixed_t yNext;

    assign yNext = y + fixed_t'(Y_SPEED);

    // clear > hit > spawn > move; a hit on a dead slot falls through to spawn
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alive <= 1'b0;
            x     <= '0;
            y     <= Y_RESET;
        end else if (clear) begin
            alive <= 1'b0;
            x     <= '0;
            y     <= Y_RESET;
        end else if (hit && alive) begin
            alive <= 1'b0;
        end else if (spawn) begin
            alive <= 1'b1;
            x     <= spawnX;
            y     <= Y_RESET;
        end else if (move && alive) begin
            if (yNext[$bits(fixed_t)-1])
                alive <= 1'b0;
            else
                y <= yNext;
        end
    end

    assign pixX = coord_t'(x >>> FP_SHIFT);
    assign pixY = coord_t'(y >>> FP_SHIFT);
endmodule

// File: rtl/player_shot_pool.sv
// Pool of player shots: lowest-free-slot allocator, fire cooldown, and alive popcount.
module player_shot_pool
    import player_shot_pkg::*;
    #(
        parameter int NUM_SHOTS       = 4,
        parameter int SHOT_Y_START    = 400,
        parameter int SHOT_X_OFFSET   = 32,
        parameter int Y_SPEED         = -320,
        parameter int COOLDOWN_FRAMES = 8
    ) (
        input logic               clk,
        input logic               resetN,
        input logic               startOfFrame,
        input logic               playGame,
        player_shot_pool_if.slave bus
    );

    localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 2);
    localparam int CNT_W = $clog2(NUM_SHOTS + 1);

    logic [NUM_SHOTS-1:0] aliveVec;
    logic [NUM_SHOTS-1:0] spawnVec;
    logic                 found;
    logic                 accept;
    logic                 clr;
    logic [CD_W-1:0]      cooldown;
    logic                 fireAcc;
    logic [CNT_W-1:0]     cnt;
    fixed_t               spawnX;
    coord_t [NUM_SHOTS-1:0] xVec;
    coord_t [NUM_SHOTS-1:0] yVec;

    assign clr    = !playGame;
    assign spawnX = (fixed_t'(bus.playerXPosition) + fixed_t'(SHOT_X_OFFSET)) <<< FP_SHIFT;

    // Allocation looks only at registered alive, so a slot freed this cycle waits a cycle
    always_comb begin
        spawnVec = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!aliveVec[i] && !found) begin
                spawnVec[i] = 1'b1;
                found       = 1'b1;
            end
        end
        accept = bus.fireReq && playGame && (cooldown == '0) && found;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cooldown <= '0;
            fireAcc  <= 1'b0;
        end else begin
            fireAcc <= accept;
            if (clr)
                cooldown <= '0;
            else if (accept)
                cooldown <= CD_W'(COOLDOWN_FRAMES);
            else if (startOfFrame && cooldown != '0)
                cooldown <= cooldown - CD_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
        player_shot_slot #(
            .SHOT_Y_START (SHOT_Y_START),
            .Y_SPEED      (Y_SPEED)
        ) u_slot (
            .clk    (clk),
            .resetN (resetN),
            .clear  (clr),
            .hit    (bus.hitMask[i]),
            .spawn  (accept && spawnVec[i]),
            .move   (startOfFrame),
            .spawnX (spawnX),
            .alive  (aliveVec[i]),
            .pixX   (xVec[i]),
            .pixY   (yVec[i])
        );
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_SHOTS; i++)
            cnt = cnt + CNT_W'(aliveVec[i]);
    end

    assign bus.alive         = aliveVec;
    assign bus.topLeftX      = xVec;
    assign bus.topLeftY      = yVec;
    assign bus.fireAccepted  = fireAcc;
    assign bus.shotsInFlight = cnt;
endmodule

// File: tb/tb_player_shot_pool.sv
// Self-checking bench: two pools (cooldown 8 and cooldown 0) driven from vector tables and sequences.
module tb_player_shot_pool;
    import player_shot_pkg::*;

    typedef struct {
        bit         en;
        string      name;
        logic [3:0] alive;
        logic       acc;
        int         cnt;
        bit         chkpos;
        logic [1:0] slot;
        int         x;
        int         y;
    } exp_t;

    typedef struct {
        bit         fire;
        bit         sof;
        logic [3:0] hit;
        int         px;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0;
    logic pg = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];

    player_shot_pool_if #(.NUM_SHOTS(4)) if0 ();
    player_shot_pool_if #(.NUM_SHOTS(4)) if1 ();

    player_shot_pool #(.NUM_SHOTS(4), .COOLDOWN_FRAMES(8)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .playGame(pg), .bus(if0.slave));
    player_shot_pool #(.NUM_SHOTS(4), .COOLDOWN_FRAMES(0)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .playGame(pg), .bus(if1.slave));

    always #5 clk = ~clk;

    function automatic exp_t mk(string n, logic [3:0] a, logic acc, int c);
        exp_t e;
        e.en = 1'b1; e.name = n; e.alive = a; e.acc = acc; e.cnt = c;
        e.chkpos = 1'b0; e.slot = 2'd0; e.x = 0; e.y = 0;
        return e;
    endfunction

    function automatic exp_t mkp(string n, logic [3:0] a, logic acc, int c,
                                 logic [1:0] s, int x, int y);
        exp_t e;
        e = mk(n, a, acc, c);
        e.chkpos = 1'b1; e.slot = s; e.x = x; e.y = y;
        return e;
    endfunction

    function automatic exp_t none();
        exp_t e;
        e = mk("skip", 4'h0, 1'b0, 0);
        e.en = 1'b0;
        return e;
    endfunction

    task automatic check(input int d, input exp_t e);
        logic [3:0] ga;
        logic       gacc;
        int         gcnt, gx, gy;
        if (d == 0) begin
            ga = if0.alive; gacc = if0.fireAccepted; gcnt = int'(if0.shotsInFlight);
            gx = int'(coord_t'(if0.topLeftX[e.slot])); gy = int'(coord_t'(if0.topLeftY[e.slot]));
        end else begin
            ga = if1.alive; gacc = if1.fireAccepted; gcnt = int'(if1.shotsInFlight);
            gx = int'(coord_t'(if1.topLeftX[e.slot])); gy = int'(coord_t'(if1.topLeftY[e.slot]));
        end
        n_chk++;
        if (ga !== e.alive) begin n_fail++; $display("FAIL %s alive got %b want %b", e.name, ga, e.alive); end
        n_chk++;
        if (gacc !== e.acc) begin n_fail++; $display("FAIL %s fireAccepted got %b want %b", e.name, gacc, e.acc); end
        n_chk++;
        if (gcnt != e.cnt) begin n_fail++; $display("FAIL %s shotsInFlight got %0d want %0d", e.name, gcnt, e.cnt); end
        if (e.chkpos) begin
            n_chk++;
            if (gx != e.x) begin n_fail++; $display("FAIL %s X[%0d] got %0d want %0d", e.name, e.slot, gx, e.x); end
            n_chk++;
            if (gy != e.y) begin n_fail++; $display("FAIL %s Y[%0d] got %0d want %0d", e.name, e.slot, gy, e.y); end
        end
    endtask

    // One clock: drive at posedge+1, expected pushed, compared at the next posedge+1
    task automatic cyc(input int d, input bit fire, input bit s, input bit p,
                       input int px, input logic [3:0] hit, input exp_t e);
        exp_t got;
        pg = p;
        sof = s;
        if (d == 0) begin
            if0.fireReq = fire; if0.playerXPosition = coord_t'(px); if0.hitMask = hit;
        end else begin
            if1.fireReq = fire; if1.playerXPosition = coord_t'(px); if1.hitMask = hit;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        sof = 1'b0;
        if0.fireReq = 1'b0; if0.hitMask = '0;
        if1.fireReq = 1'b0; if1.hitMask = '0;
        got = sb.pop_front();
        if (got.en) check(d, got);
    endtask

    vec_t tbl[6];

    initial begin
        if0.fireReq = 1'b0; if0.playerXPosition = '0; if0.hitMask = '0;
        if1.fireReq = 1'b0; if1.playerXPosition = '0; if1.hitMask = '0;

        tbl[0] = '{0, 0, 4'b0000, 0,   mkp("reset",      4'b0000, 0, 0, 0, 0,   400)};
        tbl[1] = '{1, 0, 4'b0000, 100, mkp("fire100",    4'b0001, 1, 1, 0, 132, 400)};
        tbl[2] = '{0, 1, 4'b0000, 100, mkp("frame1",     4'b0001, 0, 1, 0, 132, 395)};
        tbl[3] = '{1, 0, 4'b0000, 100, mkp("cooldown",   4'b0001, 0, 1, 0, 132, 395)};
        tbl[4] = '{0, 1, 4'b0001, 100, mkp("hit_sof",    4'b0000, 0, 0, 0, 132, 395)};
        tbl[5] = '{0, 0, 4'b0010, 100, mk ("hit_dead",   4'b0000, 0, 0)};

        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (if0.alive !== 4'b0000 || if0.shotsInFlight !== 3'd0) begin
            n_fail++; $display("FAIL in_reset alive got %b want 0000", if0.alive);
        end
        resetN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            cyc(0, tbl[i].fire, tbl[i].sof, 1'b1, tbl[i].px, tbl[i].hit, tbl[i].e);

        // Trajectory: 400 -> 0 over 80 frames, killed on the 81st
        cyc(0, 0, 0, 0, 0, 4'b0, mkp("pg_clear", 4'b0000, 0, 0, 0, 0, 400));
        cyc(0, 1, 0, 1, 0, 4'b0, mkp("fire0",    4'b0001, 1, 1, 0, 32, 400));
        cyc(0, 0, 1, 1, 0, 4'b0, mkp("fly1",     4'b0001, 0, 1, 0, 32, 395));
        for (int f = 2; f < 80; f++) cyc(0, 0, 1, 1, 0, 4'b0, none());
        cyc(0, 0, 1, 1, 0, 4'b0, mkp("fly80",    4'b0001, 0, 1, 0, 32, 0));
        cyc(0, 0, 1, 1, 0, 4'b0, mkp("fly81",    4'b0000, 0, 0, 0, 32, 0));

        // Fire every frame with cooldown 8: grants 9 frames apart
        cyc(0, 0, 0, 0, 0, 4'b0, mk("pg_clear2", 4'b0000, 0, 0));
        for (int f = 0; f < 30; f++) begin
            int k;
            k = f / 9 + 1;
            cyc(0, 1, 1, 1, 10, 4'b0, mk($sformatf("cd_f%0d", f), 4'((1 << k) - 1), (f % 9) == 0, k));
        end
        cyc(0, 0, 0, 1, 10, 4'b1000, mk("hit3",        4'b0111, 0, 3));
        cyc(0, 1, 0, 1, 10, 4'b0,    mk("cd_pending",  4'b0111, 0, 3));
        cyc(0, 0, 0, 0, 10, 4'b0,    mkp("pg_low3",    4'b0000, 0, 0, 0, 0, 400));
        cyc(0, 1, 0, 1, 7,  4'b0,    mkp("cd_cleared", 4'b0001, 1, 1, 0, 39, 400));

        // Cooldown 0 pool: fill, reject when full, reuse a hit slot
        cyc(1, 0, 0, 0, 0, 4'b0, mk("d1_clear", 4'b0000, 0, 0));
        cyc(1, 1, 0, 1, 0, 4'b0, mk("d1_f1", 4'b0001, 1, 1));
        cyc(1, 1, 0, 1, 0, 4'b0, mk("d1_f2", 4'b0011, 1, 2));
        cyc(1, 1, 0, 1, 0, 4'b0, mk("d1_f3", 4'b0111, 1, 3));
        cyc(1, 1, 0, 1, 0, 4'b0, mk("d1_f4", 4'b1111, 1, 4));
        cyc(1, 1, 0, 1, 0, 4'b0, mk("d1_full", 4'b1111, 0, 4));
        cyc(1, 0, 0, 1, 0, 4'b0100, mk("d1_hit2", 4'b1011, 0, 3));
        cyc(1, 1, 0, 1, 50, 4'b0, mkp("d1_reuse2", 4'b1111, 1, 4, 2, 82, 400));
        cyc(1, 1, 0, 1, 50, 4'b0001, mk("d1_freed_same", 4'b1110, 0, 3));
        cyc(1, 1, 0, 1, 60, 4'b0, mkp("d1_reuse0", 4'b1111, 1, 4, 0, 92, 400));
        cyc(1, 0, 0, 1, 0, 4'b1000, mk("d1_three", 4'b0111, 0, 3));
        cyc(1, 0, 0, 0, 0, 4'b0, mkp("d1_pg_low", 4'b0000, 0, 0, 1, 0, 400));

        // Reset mid-flight on the cooldown-8 pool, then fire straight away
        resetN = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc(0, 0, 0, 1, 0, 4'b0, mkp("post_reset", 4'b0000, 0, 0, 0, 0, 400));
        cyc(0, 1, 0, 1, 0, 4'b0, mkp("post_reset_fire", 4'b0001, 1, 1, 0, 32, 400));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/player_shot_pool.md
PLAYER_SHOT_POOL -- requirements
Module: player_shot_pool

Interface
REQ-001 SHALL provide parameter NUM_SHOTS, default 4, number of independent shot slots (1..8).
REQ-002 SHALL provide parameter SHOT_Y_START, default 400, spawn row in pixels.
REQ-003 SHALL provide parameter SHOT_X_OFFSET, default 32, spawn column offset from playerXPosition in pixels.
REQ-004 SHALL provide parameter Y_SPEED, default -320, per-frame Y step in 1/64-pixel units (signed).
REQ-005 SHALL provide parameter COOLDOWN_FRAMES, default 8, minimum frames between accepted fires.
REQ-006 SHALL provide port clk, input, 1, clock.
REQ-007 SHALL provide port resetN, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL provide port startOfFrame, input, 1, one-cycle pulse per video frame.
REQ-009 SHALL provide port playGame, input, 1, level; low clears all shots synchronously.
REQ-010 SHALL provide port fireReq, input, 1, one-cycle fire request.
REQ-011 SHALL provide port playerXPosition, input, 11 signed, player top-left X.
REQ-012 SHALL provide port hitMask, input, NUM_SHOTS, per-slot collision pulse.
REQ-013 SHALL provide port topLeftX, output, NUM_SHOTS x 11 signed, per-slot pixel X.
REQ-014 SHALL provide port topLeftY, output, NUM_SHOTS x 11 signed, per-slot pixel Y.
REQ-015 SHALL provide port alive, output, NUM_SHOTS, per-slot in-flight flag.
REQ-016 SHALL provide port fireAccepted, output, 1, one-cycle pulse when a fire is granted.
REQ-017 SHALL provide port shotsInFlight, output, clog2(NUM_SHOTS+1), popcount of alive.

Function
REQ-018 Each slot SHALL hold 18-bit signed fixed-point X/Y (6 fractional bits); outputs = arithmetic shift right by 6 (floor).
REQ-019 A fire SHALL be accepted when fireReq=1, playGame=1, cooldown=0 and at least one registered alive bit is 0.
REQ-020 The accepted slot SHALL be the lowest-index slot with registered alive=0; a slot freed this cycle is not eligible until next cycle.
REQ-021 On acceptance at cycle n: slot X = (playerXPosition+SHOT_X_OFFSET)*64, Y = SHOT_Y_START*64, alive=1, fireAccepted=1, all visible at n+1.
REQ-022 On acceptance the cooldown counter SHALL load COOLDOWN_FRAMES; otherwise it decrements by 1 on startOfFrame, saturating at 0.
REQ-023 On startOfFrame each alive slot SHALL add Y_SPEED to Y; X unchanged.
REQ-024 If Y + Y_SPEED < 0 on startOfFrame, the slot SHALL clear alive (off-screen kill); Y holds its last value.
REQ-025 hitMask[i]=1 SHALL clear alive[i] next cycle; hit on a dead slot is ignored.
REQ-026 Priority per slot, same cycle: playGame=0 > hit > spawn > move; a spawned slot is not moved that cycle.
REQ-027 fireReq rejected (full, cooldown, or playGame=0) SHALL be dropped, not queued; fireAccepted stays 0.
REQ-028 playGame=0 SHALL clear alive, cooldown and fireAccepted next cycle; positions return to reset values.
REQ-029 Dead slots SHALL hold last position; consumers qualify with alive.

Reset
REQ-030 On resetN=0: alive=0, fireAccepted=0, cooldown=0, all X=0, all Y=SHOT_Y_START, shotsInFlight=0.
REQ-031 Reset mid-flight SHALL discard all shots; first fire after release accepted immediately.

Structure
REQ-032 Package player_shot_pkg SHALL hold FP_SHIFT=6, coord_t (11-bit signed), fixed_t (18-bit signed).
REQ-033 Per-slot state and motion SHALL be sub-module player_shot_slot, instanced NUM_SHOTS times by generate; allocator, cooldown and popcount in top.

Verification
REQ-034 fireReq with playerX=100 -> next cycle alive=0001, X[0]=132, Y[0]=400, fireAccepted=1.
REQ-035 One shot, 1 frame -> Y=395; after 80 frames Y=0 alive; 81st frame alive=0.
REQ-036 fireReq every frame, COOLDOWN_FRAMES=8 -> accepts spaced 9 startOfFrame pulses apart.
REQ-037 COOLDOWN_FRAMES=0, 5 fires with 4 slots alive -> 5th rejected; hitMask=0100 then fire -> slot 2 reused.
REQ-038 hitMask[0] and startOfFrame same cycle -> alive[0]=0, Y[0] unchanged.
REQ-039 playGame low with 3 alive -> next cycle alive=0, shotsInFlight=0, cooldown=0.
